// File: rtl/fifo_bidir_1024x8_if.sv
// Control/status bundle for the bidirectional-bus FIFO; the shared data bus itself
// stays a plain inout wire on the FIFO so tri-state resolution happens on one net.
interface fifo_bidir_1024x8_if;
  logic read_write;
  logic enable;
  logic full;
  logic empty;

  modport master (output read_write, output enable, input full, input empty);
  modport slave  (input read_write, input enable, output full, output empty);
endinterface

// File: rtl/fifo_bidir_1024x8.sv
// Single-clock 1024x8 FIFO on a shared tri-state data bus; read_write picks push/pop,
// pops land in an output register visible on data_io one cycle later, blocked ops are dropped.
module fifo_bidir_1024x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  fifo_bidir_1024x8_if.slave  bus,
  inout  wire  [DATA_W-1:0]   data_io
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Extra wrap bit distinguishes full from empty when the low index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign push = bus.enable &  bus.read_write & ~full;
  assign pop  = bus.enable & ~bus.read_write & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is deliberately left unreset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= data_io;
    end
  end

  assign data_io   = bus.read_write ? {DATA_W{1'bz}} : dout_q;
  assign bus.full  = full;
  assign bus.empty = empty;
endmodule

// File: tb/tb_fifo_bidir_1024x8.sv
// Randomized bench for fifo_bidir_1024x8 against a queue-based reference model.
module tb_fifo_bidir_1024x8;
  localparam int DEPTH = 1024;

  logic       clk;
  logic       rst;
  logic       tb_oe;
  logic [7:0] tb_dat;
  wire  [7:0] data_io;

  fifo_bidir_1024x8_if bus_if ();

  fifo_bidir_1024x8 dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .data_io (data_io)
  );

  assign data_io = tb_oe ? tb_dat : 8'hzz;

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_q[$];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] got_aa  = 8'h00;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One operation: drive at negedge, update model at posedge, check at next negedge.
  task automatic op(input string tag, input logic rw, input logic en, input logic [7:0] d);
    bus_if.read_write = rw;
    bus_if.enable     = en;
    tb_oe             = rw;
    tb_dat            = d;
    @(posedge clk);
    if (en && rw && model_q.size() < DEPTH) model_q.push_back(d);
    else if (en && !rw && model_q.size() > 0) last_rd = model_q.pop_front();
    @(negedge clk);
    chk({tag, ".empty"}, 16'(bus_if.empty), 16'(model_q.size() == 0));
    chk({tag, ".full"},  16'(bus_if.full),  16'(model_q.size() == DEPTH));
    if (!rw) chk({tag, ".data"}, 16'(data_io), 16'(last_rd));
    else     chk({tag, ".bus_released"}, 16'(data_io), 16'(d));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b0;
    bus_if.read_write = 1'b1;
    bus_if.enable     = 1'b0;
    tb_oe             = 1'b1;
    tb_dat            = 8'h5a;
    #10;
    chk("reset.empty", 16'(bus_if.empty), 16'd1);
    chk("reset.full",  16'(bus_if.full),  16'd0);
    chk("reset.bus_released", 16'(data_io), 16'h5a);
    bus_if.read_write = 1'b0;
    tb_oe             = 1'b0;
    #5;
    chk("reset.dout", 16'(data_io), 16'h00);
    #15 rst = 1'b1;
    @(negedge clk);

    // Fill to exactly DEPTH words, first word fixed.
    op("fill", 1'b1, 1'b1, 8'd122);
    for (int i = 1; i < DEPTH; i++) op("fill", 1'b1, 1'b1, 8'($urandom_range(0, 169)));

    // Overflow attempt with a marker value that never appears in the fill data.
    op("overflow", 1'b1, 1'b1, 8'haa);

    // Drain in order; first pop must return 122.
    op("drain", 1'b0, 1'b1, 8'h00);
    chk("drain.first", 16'(data_io), 16'd122);
    for (int i = 1; i < DEPTH; i++) begin
      op("drain", 1'b0, 1'b1, 8'h00);
      if (data_io == 8'haa) got_aa = 8'haa;
    end
    chk("overflow.not_stored", 16'(got_aa), 16'h00);

    // Underflow: output register must hold.
    for (int i = 0; i < 4; i++) op("underflow", 1'b0, 1'b1, 8'h00);

    // Disabled cycles in both directions change nothing.
    op("idle", 1'b1, 1'b0, 8'h33);
    op("idle", 1'b0, 1'b0, 8'h00);

    // Random mixed traffic, including boundary hits near empty.
    for (int i = 0; i < 1500; i++) begin
      logic rw, en;
      rw = ($urandom_range(0, 99) < 55);
      en = ($urandom_range(0, 99) < 85);
      op("rand", rw, en, 8'($urandom));
    end

    // Asynchronous reset between clock edges mid-fill.
    for (int i = 0; i < 5; i++) op("prereset", 1'b1, 1'b1, 8'($urandom));
    bus_if.enable = 1'b0;
    @(posedge clk);
    #10 rst = 1'b0;
    #1;
    chk("async_reset.empty", 16'(bus_if.empty), 16'd1);
    chk("async_reset.full",  16'(bus_if.full),  16'd0);
    #5 rst = 1'b1;
    model_q.delete();
    last_rd = 8'h00;
    @(negedge clk);
    op("post_reset_pop", 1'b0, 1'b1, 8'h00);
    op("post_reset_push", 1'b1, 1'b1, 8'h3c);
    op("post_reset_pop", 1'b0, 1'b1, 8'h00);
    chk("post_reset.value", 16'(data_io), 16'h3c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
